ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter that sends one command byte, such as 0xED set-LEDs or 0xFF reset, to the keyboard on the pmod PS/2 port. It performs the full host request sequence: clock inhibit, start bit, data/parity/stop clocked by the device, and ACK check. It sits beside the existing PS/2 receive path, which reads the clock and data lines and can inhibit the clock. The top level ORs `ps2_clk_oe` with the existing clock-inhibit bit, and drives the data pin low through an SB_IO output enable gated by `ps2_data_oe`.

## Interface
- `INHIBIT_CYCLES`, 5000: clk_core cycles the clock is held low before the start bit. Must be ≥100 µs at clk_core.
- `START_CYCLES`, 16: cycles both lines are held low before the clock is released.
- `TIMEOUT_CYCLES`, 600000: maximum clk_core cycles allowed between device clock events. Must be ≥15 ms.
- `clk_core`  in  1  core clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `tx_valid`  in  1  byte-send request.
- `tx_data`  in  8  byte to send, LSB first.
- `tx_ready`  out  1  block idle; a request is accepted when `tx_valid & tx_ready`.
- `ps2_clk_in`  in  1  raw PS/2 clock pin level, asynchronous.
- `ps2_data_in`  in  1  raw PS/2 data pin level, asynchronous.
- `ps2_clk_oe`  out  1  1 = drive the clock line low.
- `ps2_data_oe`  out  1  1 = drive the data line low.
- `done`  out  1  one-cycle pulse at the end of a transaction.
- `err_nack`  out  1  device did not ACK; valid only with `done`.
- `err_timeout`  out  1  device clock timed out; valid only with `done`.

## Operation
- **Input conditioning.** `ps2_clk_in` and `ps2_data_in` each pass through a 2-flop synchronizer. A falling edge ("fall") is synchronized clock 1 in the previous cycle and 0 in the current cycle.
- **Accept.** On acceptance, latch `tx_data` and form a 10-bit shift register = {1 (stop), ~^tx_data (odd parity), tx_data}.
- **States.**
  - IDLE: `tx_ready`=1, both OEs 0. On accept, go to INHIBIT and clear the counter.
  - INHIBIT: `ps2_clk_oe`=1 for INHIBIT_CYCLES cycles, then go to START.
  - START: `ps2_clk_oe`=1 and `ps2_data_oe`=1 for START_CYCLES cycles, then go to BITS with `ps2_clk_oe`=0 and `ps2_data_oe` held at 1 (start bit).
  - BITS: on each fall, `ps2_data_oe` <= ~shift[0], shift right, bitcount+1. The tenth fall presents the stop bit (OE=0); go to ACK.
  - ACK: on the next fall, sample synchronized data. 0 = ACK, 1 = record nack. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until synchronized clock and data are both 1, then go to DONE.
  - DONE: one cycle. `done`=1, `err_nack` as recorded, `err_timeout`=0. Return to IDLE.
- **Timeout.** In BITS, ACK and WAIT_IDLE, the counter clears on every fall and increments otherwise. On reaching TIMEOUT_CYCLES:
  - both OEs go to 0 on the next cycle;
  - `done`=1 with `err_timeout`=1 and `err_nack`=0;
  - the block returns to IDLE.
- **Requests while busy.** `tx_valid` while `tx_ready`=0 is ignored; no queueing. `tx_data` is sampled only at accept.
- **Shared clock line.** The block never senses its own drive. Clock falls during INHIBIT and START are ignored.

## Timing
- **Reset values.** `tx_ready`=1, `ps2_clk_oe`=0, `ps2_data_oe`=0, `done`=0, `err_nack`=0, `err_timeout`=0, state IDLE, counter 0.
- **Reset mid-transaction.** A reset sampled in any state forces all outputs to their reset values on that edge. Both lines are released immediately and no `done` is issued.
- **Registered outputs.** All outputs are registered.
  - `tx_ready` falls the cycle after accept.
  - `ps2_clk_oe` rises the cycle after accept.
- **Edge latency.** Fall-to-`ps2_data_oe` update is 3 cycles after the pin edge: 2 synchronizer cycles + 1 register.
- **Clock low duration.** Clock is held low for exactly INHIBIT_CYCLES+START_CYCLES cycles.
- **Data low before release.** Data is low START_CYCLES cycles before the clock is released.
- **Back-to-back.** `tx_ready` returns to 1 the cycle after `done`. A new request may be accepted in that cycle.
- **`done` with simultaneous timeout.** If a fall and a timeout occur in the same cycle, the fall wins and the counter clears.

## Test plan
- Send 0xED with a device model that clocks at 12.5 kHz and ACKs.
  - Device samples on rising edges: start 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - `done` pulses with both errors 0.
  - `tx_ready` rises the cycle after `done`.
- Send 0x00 and 0xF4.
  - Parity bits are 1 and 0 respectively.
  - Clock low measured from accept+1 is exactly 5016 cycles.
  - `ps2_data_oe` rises at cycle 5001.
- Device releases data (1) at the ACK fall.
  - `done` with `err_nack`=1 and `err_timeout`=0.
  - OEs are 0 after the stop bit.
- Device never clocks.
  - 600000 cycles after the clock is released: `done`, `err_timeout`=1, both OEs 0, back in IDLE.
- Assert `reset` for 1 cycle after the 4th data fall.
  - Both OEs and `done` are 0 on the next edge.
  - `tx_ready`=1; no `done` pulse follows.
  - A fresh 0xFF then sends correctly with parity 1.
- Hold `tx_valid` with `tx_data`=0xAA through a 0x55 transaction.
  - 0x55 is sent unaltered.
  - 0xAA is accepted on the cycle after `done`, and `ps2_clk_oe` rises the cycle after that.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, presents a start bit, then
// shifts out one byte plus odd parity and stop on device clock falls and checks the ACK.
//
// state     | meaning
// IDLE      | ready for a request, both lines released
// INHIBIT   | clock held low
// START     | clock and data held low
// BITS      | data, parity and stop shifted out on device clock falls
// ACK       | waiting for the device ACK fall
// WAIT_IDLE | waiting for both lines to return high
// DONE      | one-cycle completion pulse
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 600000
) (
    input  logic       clk_core,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       done,
    output logic       err_nack,
    output logic       err_timeout
);

    localparam int CNT_MAX_A = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        BITS,
        ACK,
        WAIT_IDLE,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [9:0]       shift, shift_nx;
    logic [3:0]       bit_cnt, bit_cnt_nx;
    logic             nack, nack_nx;

    logic tx_ready_nx, clk_oe_nx, data_oe_nx, done_nx, err_nack_nx, err_timeout_nx;

    logic clk_s1, clk_s2, clk_d;
    logic data_s1, data_s2;
    logic fall;
    logic tmo_hit;

    // Synchronizers idle high so a reset never creates a phantom fall.
    always_ff @(posedge clk_core) begin
        if (reset) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_d   <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk_in;
            clk_s2  <= clk_s1;
            clk_d   <= clk_s2;
            data_s1 <= ps2_data_in;
            data_s2 <= data_s1;
        end
    end

    assign fall = clk_d & ~clk_s2;

    always_ff @(posedge clk_core) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            shift       <= '0;
            bit_cnt     <= '0;
            nack        <= 1'b0;
            tx_ready    <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            err_nack    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            shift       <= shift_nx;
            bit_cnt     <= bit_cnt_nx;
            nack        <= nack_nx;
            tx_ready    <= tx_ready_nx;
            ps2_clk_oe  <= clk_oe_nx;
            ps2_data_oe <= data_oe_nx;
            done        <= done_nx;
            err_nack    <= err_nack_nx;
            err_timeout <= err_timeout_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        shift_nx       = shift;
        bit_cnt_nx     = bit_cnt;
        nack_nx        = nack;
        tx_ready_nx    = 1'b0;
        clk_oe_nx      = ps2_clk_oe;
        data_oe_nx     = ps2_data_oe;
        done_nx        = 1'b0;
        err_nack_nx    = 1'b0;
        err_timeout_nx = 1'b0;
        tmo_hit        = 1'b0;

        // Watchdog down-counter: reloaded on every device fall, a fall beats expiry.
        if (state == BITS || state == ACK || state == WAIT_IDLE) begin
            if (fall) begin
                cnt_nx = CNT_W'(TIMEOUT_CYCLES - 1);
            end else if (cnt == '0) begin
                tmo_hit = 1'b1;
            end else begin
                cnt_nx = cnt - CNT_W'(1);
            end
        end

        case (state)
            IDLE: begin
                tx_ready_nx = 1'b1;
                clk_oe_nx   = 1'b0;
                data_oe_nx  = 1'b0;
                if (tx_valid && tx_ready) begin
                    state_nx    = INHIBIT;
                    cnt_nx      = CNT_W'(INHIBIT_CYCLES - 1);
                    shift_nx    = {1'b1, ~^tx_data, tx_data};
                    bit_cnt_nx  = '0;
                    nack_nx     = 1'b0;
                    clk_oe_nx   = 1'b1;
                    tx_ready_nx = 1'b0;
                end
            end
            INHIBIT: begin
                clk_oe_nx = 1'b1;
                if (cnt == '0) begin
                    state_nx   = START;
                    cnt_nx     = CNT_W'(START_CYCLES - 1);
                    data_oe_nx = 1'b1;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            START: begin
                if (cnt == '0) begin
                    state_nx  = BITS;
                    cnt_nx    = CNT_W'(TIMEOUT_CYCLES - 1);
                    clk_oe_nx = 1'b0;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            BITS: begin
                if (!tmo_hit && fall) begin
                    data_oe_nx = ~shift[0];
                    shift_nx   = {1'b0, shift[9:1]};
                    bit_cnt_nx = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd9) begin
                        state_nx = ACK;
                    end
                end
            end
            ACK: begin
                if (!tmo_hit && fall) begin
                    nack_nx  = data_s2;
                    state_nx = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (!tmo_hit && clk_s2 && data_s2) begin
                    state_nx    = DONE;
                    done_nx     = 1'b1;
                    err_nack_nx = nack;
                    clk_oe_nx   = 1'b0;
                    data_oe_nx  = 1'b0;
                end
            end
            DONE: begin
                state_nx    = IDLE;
                cnt_nx      = '0;
                tx_ready_nx = 1'b1;
                clk_oe_nx   = 1'b0;
                data_oe_nx  = 1'b0;
            end
            default: begin
                state_nx    = IDLE;
                cnt_nx      = '0;
                tx_ready_nx = 1'b1;
                clk_oe_nx   = 1'b0;
                data_oe_nx  = 1'b0;
            end
        endcase

        if (tmo_hit) begin
            state_nx       = DONE;
            done_nx        = 1'b1;
            err_timeout_nx = 1'b1;
            err_nack_nx    = 1'b0;
            clk_oe_nx      = 1'b0;
            data_oe_nx     = 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a wired-AND line model plus a device that clocks
// the frame out, samples on rising clock edges and optionally ACKs.
module tb_ps2_host_tx;

    localparam int TMO  = 2000;   // shortened watchdog to keep the run small
    localparam int HALF = 20;     // device clock half period in core cycles (scaled)

    logic       clk_core = 1'b0;
    logic       reset;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       done;
    logic       err_nack;
    logic       err_timeout;
    logic       dev_clk_low;
    logic       dev_data_low;

    int checks = 0;
    int errors = 0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    always #5 clk_core = ~clk_core;

    ps2_host_tx #(
        .INHIBIT_CYCLES(5000),
        .START_CYCLES  (16),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_core   (clk_core),
        .reset      (reset),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .done       (done),
        .err_nack   (err_nack),
        .err_timeout(err_timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_core);
    endtask

    task automatic send_accept(input logic [7:0] b);
        int n;
        n = 0;
        while (!tx_ready && n < 200) begin
            step();
            n++;
        end
        tx_valid = 1'b1;
        tx_data  = b;
        step();
        tx_valid = 1'b0;
    endtask

    // Entered on the cycle after accept; returns on the cycle the clock is released.
    task automatic run_inhibit(input string tag);
        int k, data_k, rel_k;
        k = 1;
        data_k = 0;
        rel_k = 0;
        check_eq({tag, "_ready_low"}, 32'(tx_ready), 0);
        check_eq({tag, "_clk_oe_rise"}, 32'(ps2_clk_oe), 1);
        while (rel_k == 0 && k < 6000) begin
            step();
            k++;
            if (data_k == 0 && ps2_data_oe) data_k = k;
            if (!ps2_clk_oe) rel_k = k;
        end
        check_eq({tag, "_data_oe_at"}, 32'(data_k), 5001);
        check_eq({tag, "_clk_low_len"}, 32'(rel_k - 1), 5016);
    endtask

    task automatic device_xfer(input string tag, input logic [10:0] frame, input bit ack,
                               input int abort_at);
        logic [10:0] seen;
        int nd;
        seen = '0;
        seen[0] = ps2_data_in;
        for (int i = 1; i <= 10; i++) begin
            repeat (HALF) step();
            dev_clk_low = 1'b1;
            repeat (HALF) step();
            if (i == abort_at) begin
                reset = 1'b1;
                step();
                check_eq({tag, "_rst_clk_oe"}, 32'(ps2_clk_oe), 0);
                check_eq({tag, "_rst_data_oe"}, 32'(ps2_data_oe), 0);
                check_eq({tag, "_rst_done"}, 32'(done), 0);
                check_eq({tag, "_rst_ready"}, 32'(tx_ready), 1);
                reset = 1'b0;
                dev_clk_low = 1'b0;
                nd = 0;
                repeat (100) begin
                    step();
                    if (done) nd++;
                end
                check_eq({tag, "_no_done"}, 32'(nd), 0);
                return;
            end
            dev_clk_low = 1'b0;
            seen[i] = ps2_data_in;
        end
        check_eq({tag, "_frame"}, 32'(seen), 32'(frame));
        check_eq({tag, "_parity"}, 32'(seen[9]), 32'(frame[9]));
        check_eq({tag, "_oe_after_stop"}, 32'({ps2_clk_oe, ps2_data_oe}), 0);
        repeat (HALF) step();
        dev_data_low = ack;
        repeat (HALF / 2) step();
        dev_clk_low = 1'b1;
        repeat (HALF) step();
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit exp_nack, input bit exp_tmo,
                             input int max_wait, output int waited);
        waited = 0;
        while (!done && waited < max_wait) begin
            step();
            waited++;
        end
        check_eq({tag, "_done"}, 32'(done), 1);
        check_eq({tag, "_err_nack"}, 32'(err_nack), 32'(exp_nack));
        check_eq({tag, "_err_timeout"}, 32'(err_timeout), 32'(exp_tmo));
        check_eq({tag, "_oe_at_done"}, 32'({ps2_clk_oe, ps2_data_oe}), 0);
        step();
        check_eq({tag, "_ready_after"}, 32'(tx_ready), 1);
        check_eq({tag, "_done_one_cycle"}, 32'(done), 0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) step();
        check_eq("rst_ready", 32'(tx_ready), 1);
        check_eq("rst_clk_oe", 32'(ps2_clk_oe), 0);
        check_eq("rst_data_oe", 32'(ps2_data_oe), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_errs", 32'({err_nack, err_timeout}), 0);
        reset = 1'b0;
        step();

        // frame = {stop, parity, data, start}, parity hand-computed (odd)
        send_accept(8'hED);
        run_inhibit("ed");
        device_xfer("ed", {1'b1, 1'b1, 8'hED, 1'b0}, 1'b1, 0);
        wait_done("ed", 1'b0, 1'b0, 200, n);

        send_accept(8'h00);
        run_inhibit("x00");
        device_xfer("x00", {1'b1, 1'b1, 8'h00, 1'b0}, 1'b1, 0);
        wait_done("x00", 1'b0, 1'b0, 200, n);

        send_accept(8'hF4);
        run_inhibit("xf4");
        device_xfer("xf4", {1'b1, 1'b0, 8'hF4, 1'b0}, 1'b1, 0);
        wait_done("xf4", 1'b0, 1'b0, 200, n);

        send_accept(8'h12);
        run_inhibit("nack");
        device_xfer("nack", {1'b1, 1'b1, 8'h12, 1'b0}, 1'b0, 0);
        wait_done("nack", 1'b1, 1'b0, 200, n);

        send_accept(8'h00);
        run_inhibit("tmo");
        wait_done("tmo", 1'b0, 1'b1, TMO + 100, n);
        check_eq("tmo_cycles", 32'(n), 32'(TMO));

        send_accept(8'hC3);
        run_inhibit("abort");
        device_xfer("abort", {1'b1, 1'b1, 8'hC3, 1'b0}, 1'b1, 4);

        send_accept(8'hFF);
        run_inhibit("xff");
        device_xfer("xff", {1'b1, 1'b1, 8'hFF, 1'b0}, 1'b1, 0);
        wait_done("xff", 1'b0, 1'b0, 200, n);

        n = 0;
        while (!tx_ready && n < 200) begin
            step();
            n++;
        end
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        step();
        tx_data  = 8'hAA;
        run_inhibit("x55");
        device_xfer("x55", {1'b1, 1'b1, 8'h55, 1'b0}, 1'b1, 0);
        wait_done("x55", 1'b0, 1'b0, 200, n);
        check_eq("aa_clk_oe_before", 32'(ps2_clk_oe), 0);
        step();
        tx_valid = 1'b0;
        run_inhibit("xaa");
        device_xfer("xaa", {1'b1, 1'b1, 8'hAA, 1'b0}, 1'b1, 0);
        wait_done("xaa", 1'b0, 1'b0, 200, n);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
